washer_plant: RTL

WASHER_PLANT -- requirements
Module: washer_plant

---
 rtl/washer_plant.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/washer_plant.sv
// Washer plant model: water level, wash-phase sequencer, soap/wash/spin timers, misuse flag.
// Latency: every output is a register or a decode of one; effects appear on the edge after the commands.
// Backpressure: none. Commands are sampled on every rising edge.
// Ports: clk, reset (async active-low)
//        door_lock, motor_on, fill_value_on, drain_value_on, soap_wash, water_wash  (controller commands)
//        filled, drained, level[3:0]  (water level and its sensors)
//        detergent_added, cycle_timeout, spin_timeout  (sticky timer flags)
//        phase[2:0], fault  (plant phase and sticky misuse flag)
module washer_plant #(
  parameter int LEVEL_MAX   = 8,
  parameter int DET_CYCLES  = 2,
  parameter int WASH_CYCLES = 4,
  parameter int SPIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       door_lock,
  input  logic       motor_on,
  input  logic       fill_value_on,
  input  logic       drain_value_on,
  input  logic       soap_wash,
  input  logic       water_wash,
  output logic       filled,
  output logic       drained,
  output logic       detergent_added,
  output logic       cycle_timeout,
  output logic       spin_timeout,
  output logic [3:0] level,
  output logic [2:0] phase,
  output logic       fault
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] FILL     = 3'd1;
  localparam logic [2:0] WASH     = 3'd2;
  localparam logic [2:0] DRAIN    = 3'd3;
  localparam logic [2:0] SPIN     = 3'd4;
  localparam logic [2:0] COMPLETE = 3'd5;

  localparam logic [3:0] LVL_FULL  = 4'(LEVEL_MAX);
  localparam logic [3:0] DET_TERM  = 4'(DET_CYCLES);
  localparam logic [3:0] WASH_TERM = 4'(WASH_CYCLES);
  localparam logic [3:0] SPIN_TERM = 4'(SPIN_CYCLES);

  logic [2:0] phase_nxt;
  logic       enter_idle;
  logic [3:0] det_cnt;
  logic [3:0] wash_cnt;
  logic [3:0] spin_cnt;

  // water_wash is a mode indication the plant only observes.
  logic unused_water_wash;
  assign unused_water_wash = water_wash;

  assign filled  = (level == LVL_FULL);
  assign drained = (level == 4'd0);

  // Water level: fill needs the door locked, drain does not; opposing
  // valves cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= 4'd0;
    end else if (fill_value_on && !drain_value_on && door_lock) begin
      if (level != LVL_FULL) level <= level + 4'd1;
    end else if (drain_value_on && !fill_value_on) begin
      if (level != 4'd0) level <= level - 4'd1;
    end
  end

  // Phase sequencer. Unlocking the door in any active phase aborts to IDLE
  // ahead of the normal transition.
  always_comb begin
    phase_nxt = phase;
    case (phase)
      IDLE:     if (door_lock && fill_value_on) phase_nxt = FILL;
      FILL:     if (!door_lock) phase_nxt = IDLE;
                else if (filled && motor_on) phase_nxt = WASH;
      WASH:     if (!door_lock) phase_nxt = IDLE;
                else if (drain_value_on) phase_nxt = DRAIN;
      DRAIN:    if (!door_lock) phase_nxt = IDLE;
                else if (drained && motor_on) phase_nxt = SPIN;
      SPIN:     if (!door_lock) phase_nxt = IDLE;
                else if (spin_timeout) phase_nxt = COMPLETE;
      COMPLETE: if (!door_lock) phase_nxt = IDLE;
      default:  phase_nxt = IDLE;
    endcase
  end

  // Counters and flags are wiped on every arrival in IDLE (normal or abort).
  assign enter_idle = (phase_nxt == IDLE) && (phase != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= IDLE;
    end else begin
      phase <= phase_nxt;
    end
  end

  // Timers count the qualifying edges of the current phase and saturate at
  // their terminal value; each flag rises on the edge the terminal is reached.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      det_cnt         <= 4'd0;
      wash_cnt        <= 4'd0;
      spin_cnt        <= 4'd0;
      detergent_added <= 1'b0;
      cycle_timeout   <= 1'b0;
      spin_timeout    <= 1'b0;
    end else if (enter_idle) begin
      det_cnt         <= 4'd0;
      wash_cnt        <= 4'd0;
      spin_cnt        <= 4'd0;
      detergent_added <= 1'b0;
      cycle_timeout   <= 1'b0;
      spin_timeout    <= 1'b0;
    end else begin
      if (phase == WASH && soap_wash && det_cnt != DET_TERM) begin
        det_cnt <= det_cnt + 4'd1;
        if (det_cnt + 4'd1 == DET_TERM) detergent_added <= 1'b1;
      end
      if (phase == WASH && motor_on && !drain_value_on && wash_cnt != WASH_TERM) begin
        wash_cnt <= wash_cnt + 4'd1;
        if (wash_cnt + 4'd1 == WASH_TERM) cycle_timeout <= 1'b1;
      end
      if (phase == SPIN && motor_on && drain_value_on && spin_cnt != SPIN_TERM) begin
        spin_cnt <= spin_cnt + 4'd1;
        if (spin_cnt + 4'd1 == SPIN_TERM) spin_timeout <= 1'b1;
      end
    end
  end

  // Misuse: running the motor or filling with the door unlocked. Sticky
  // until reset and purely informational; the sequencer ignores it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault <= 1'b0;
    end else if (!door_lock && (motor_on || fill_value_on)) begin
      fault <= 1'b1;
    end
  end

endmodule
